// File: rtl/flow_entropy_arbiter.sv
// Per-flow entropy accumulator and classifier; streams the encrypted-flow bitmap out in RESULT_W-bit words.
// Optional statistics counters are built when FLOW_ARB_STATS_EN is defined.
module flow_entropy_arbiter #(
    parameter int FLOW_NUM_W    = 16,
    parameter int MAX_FLOWS     = 256,
    parameter int ENT_W         = 16,
    parameter int PKTS_PER_FLOW = 8,
    parameter int RESULT_W      = 64
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [ENT_W-1:0]      i_pkt_entropy,
    input  logic                  i_pkt_entropy_valid,
    output logic                  o_pkt_entropy_ready,
    input  logic [FLOW_NUM_W-1:0] i_flow_num,
    input  logic [ENT_W-1:0]      i_threshold,
    input  logic [FLOW_NUM_W-1:0] i_flow_total,
    output logic [RESULT_W-1:0]   o_result_word,
    output logic [7:0]            o_result_idx,
    output logic                  o_result_valid,
    input  logic                  i_result_ready,
    output logic                  o_calc_complete,
    output logic                  o_err_flow_range
`ifdef FLOW_ARB_STATS_EN
    ,
    output logic [31:0]           o_stat_pkts,
    output logic [31:0]           o_stat_drops,
    output logic [15:0]           o_stat_enc
`endif
);

    localparam int LOG2P  = $clog2(PKTS_PER_FLOW);
    localparam int SUM_W  = ENT_W + LOG2P;
    localparam int CNT_W  = LOG2P + 1;
    localparam int FIDX_W = $clog2(MAX_FLOWS);
    localparam int NWORDS = MAX_FLOWS / RESULT_W;
    localparam int DONE_W = FLOW_NUM_W + 1;

    localparam logic [DONE_W-1:0] FLOWS_LIM = DONE_W'(MAX_FLOWS);
    localparam logic [DONE_W-1:0] DONE_ONE  = DONE_W'(1);
    localparam logic [CNT_W-1:0]  PKTS_C    = CNT_W'(PKTS_PER_FLOW);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [FIDX_W-1:0] CLR_LAST  = FIDX_W'(MAX_FLOWS - 1);
    localparam logic [FIDX_W-1:0] CLR_ONE   = FIDX_W'(1);
    localparam logic [7:0]        WORD_LAST = 8'(NWORDS - 1);

    typedef enum logic [1:0] {
        S_CLEAR,
        S_ACCUM,
        S_DRAIN
    } state_t;

    state_t                 state;
    logic [FIDX_W-1:0]      clear_idx;
    logic [DONE_W-1:0]      flows_done;
    logic [MAX_FLOWS-1:0]   bitmap;

    logic [SUM_W-1:0]       sum_mem [MAX_FLOWS];
    logic [CNT_W-1:0]       cnt_mem [MAX_FLOWS];

    logic                   beat_acc;
    logic                   in_range;
    logic [FIDX_W-1:0]      flow_idx;
    logic [SUM_W-1:0]       cur_sum;
    logic [CNT_W-1:0]       cur_cnt;
    logic [SUM_W-1:0]       sum_new;
    logic [CNT_W-1:0]       cnt_new;
    logic [ENT_W-1:0]       mean;
    logic                   upd;
    logic                   fin;
    logic                   enc;
    logic [DONE_W-1:0]      total_eff;
    logic [7:0]             sel_idx;
    logic [RESULT_W-1:0]    word_sel;

    assign o_pkt_entropy_ready = (state == S_ACCUM);

    // Table read is combinational so back-to-back beats to one flow see the previous cycle's write.
    always_comb begin
        beat_acc  = (state == S_ACCUM) && i_pkt_entropy_valid;
        in_range  = ({1'b0, i_flow_num} < FLOWS_LIM);
        flow_idx  = i_flow_num[FIDX_W-1:0];
        cur_sum   = sum_mem[flow_idx];
        cur_cnt   = cnt_mem[flow_idx];
        sum_new   = cur_sum + {{LOG2P{1'b0}}, i_pkt_entropy};
        cnt_new   = cur_cnt + CNT_ONE;
        mean      = sum_new[SUM_W-1:LOG2P];
        upd       = beat_acc && in_range && (cur_cnt < PKTS_C);
        fin       = upd && (cnt_new == PKTS_C);
        enc       = (mean >= i_threshold);
        total_eff = (i_flow_total == '0) ? DONE_ONE : {1'b0, i_flow_total};
    end

    // Word to load next: slice 0 on DRAIN entry, otherwise the slice after the current one.
    always_comb begin
        sel_idx  = (state == S_DRAIN) ? (o_result_idx + 8'd1) : 8'd0;
        word_sel = '0;
        for (int w = 0; w < NWORDS; w++) begin
            if (sel_idx == 8'(w)) begin
                word_sel = bitmap[w*RESULT_W +: RESULT_W];
            end
        end
    end

    // NOTE: the flow table has no reset branch; reset forces CLEAR, which scrubs one entry per cycle.
    always_ff @(posedge i_clk) begin
        if (state == S_CLEAR) begin
            sum_mem[clear_idx] <= '0;
            cnt_mem[clear_idx] <= '0;
        end else if (upd) begin
            sum_mem[flow_idx] <= sum_new;
            cnt_mem[flow_idx] <= cnt_new;
        end
    end

    // NOTE: all state updates use non-blocking assignments so every branch reads pre-edge values.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state            <= S_CLEAR;
            clear_idx        <= '0;
            flows_done       <= '0;
            bitmap           <= '0;
            o_result_word    <= '0;
            o_result_idx     <= '0;
            o_result_valid   <= 1'b0;
            o_calc_complete  <= 1'b0;
            o_err_flow_range <= 1'b0;
        end else begin
            o_calc_complete <= 1'b0;
            if (beat_acc && !in_range) begin
                o_err_flow_range <= 1'b1;
            end
            case (state)
                S_ACCUM: begin
                    if (fin) begin
                        bitmap[flow_idx] <= enc;
                        flows_done       <= flows_done + DONE_ONE;
                    end
                    if (flows_done == total_eff) begin
                        state          <= S_DRAIN;
                        o_result_valid <= 1'b1;
                        o_result_idx   <= 8'd0;
                        o_result_word  <= word_sel;
                    end
                end
                S_DRAIN: begin
                    if (i_result_ready) begin
                        if (o_result_idx == WORD_LAST) begin
                            o_result_valid  <= 1'b0;
                            o_calc_complete <= 1'b1;
                            clear_idx       <= '0;
                            state           <= S_CLEAR;
                        end else begin
                            o_result_idx  <= sel_idx;
                            o_result_word <= word_sel;
                        end
                    end
                end
                S_CLEAR: begin
                    clear_idx <= clear_idx + CLR_ONE;
                    if (clear_idx == CLR_LAST) begin
                        bitmap     <= '0;
                        flows_done <= '0;
                        state      <= S_ACCUM;
                    end
                end
                default: begin
                    state <= S_CLEAR;
                end
            endcase
        end
    end

`ifdef FLOW_ARB_STATS_EN
    // Counters only move in ACCUM, so they hold still for the whole DRAIN.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n || (state == S_CLEAR)) begin
            o_stat_pkts  <= '0;
            o_stat_drops <= '0;
            o_stat_enc   <= '0;
        end else if (beat_acc) begin
            o_stat_pkts <= o_stat_pkts + 32'd1;
            if (!upd) begin
                o_stat_drops <= o_stat_drops + 32'd1;
            end
            if (fin && enc) begin
                o_stat_enc <= o_stat_enc + 16'd1;
            end
        end
    end
`endif

endmodule
